fp_mul_pipe: RTL
================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754 binary multiplier (binary32 default); successor to the combinational FP multiplier.
//  Adds valid/ready flow control on both sides, five rounding modes, IEEE exception flags and optional sticky flag accumulation.
//  Sits in the FPU datapath between operand issue and result writeback.
//  Subnormal inputs and outputs are flushed to signed zero (FTZ/DAZ).
// PARAMETERS
//  EXP_W  8   exponent width; BIAS = 2**(EXP_W-1)-1
//  FRC_W  23  stored fraction width; significand = FRC_W+1 bits
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           asynchronous reset, active low
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           pipeline accepts operands this cycle
//  fp_x       in   EXP_W+FRC_W+1  operand X
//  fp_y       in   EXP_W+FRC_W+1  operand Y
//  r_mode     in   3           000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE
//  out_valid  out  1           result valid
//  out_ready  in   1           consumer takes result this cycle
//  fp_z       out  EXP_W+FRC_W+1  product
//  flags      out  4           {nv, of, uf, nx} for the fp_z currently presented
//  sticky     out  4           accumulated flags (see CONFIGURATION)
//  sticky_clr in   1           synchronous clear of sticky
// BEHAVIOUR
//  Reset: all stage valids=0; out_valid=0, fp_z=0, flags=0, sticky=0; in_ready=1 from the first cycle after reset.
//  Pipeline: S1 unpack/classify/sign/exponent sum; S2 significand product; S3 normalise/round/pack. S3 is the output register.
//  Latency: 3 cycles from accept (in_valid&in_ready) to out_valid with out_ready=1.
//  Advance: adv3 = !v3|out_ready; adv2 = !v2|adv3; adv1 = !v1|adv2; in_ready = adv1 (combinational chain).
//  Throughput: 1 op/cycle. A stage holds its data while it is blocked. There are no bubbles and no drops, and order is preserved.
//  Back-pressure: 3 results can be in flight. After that, in_ready drops.
//  out_valid holds until it is taken. fp_z and flags stay stable while out_valid & !out_ready.
//  Each op uses its own r_mode, captured in S1.
//  Classify: exp==0 -> zero (DAZ, fraction ignored). exp==all-1 with frac==0 -> inf. exp==all-1 with frac!=0 -> NaN; sNaN when frac MSB=0.
//  Sign of a non-NaN result: sx^sy.
//  Special cases, in priority order:
//    NaN input or inf*zero -> canonical qNaN {0,1..1,1,0..0}.
//      nv=1 if inf*zero or either input is sNaN.
//    inf*nonzero -> signed inf, no flags.
//    zero*finite -> signed zero, no flags.
//  Arithmetic: product P = 2*(FRC_W+1) bits. norm_n = P[MSB]. When norm_n=0, P shifts left 1.
//    Keep FRC_W+1 bits; then guard, round, sticky = OR of the rest.
//  Exponent: computed signed in EXP_W+2 bits: E = ex+ey-BIAS+norm_n. A rounding carry-out renormalises the result and adds 1 to E.
//  nx = any discarded bit nonzero.
//  Rounding increment: RNE g&(r|s|lsb); RTZ 0; RDN sign&(g|r|s); RUP !sign&(g|r|s); RMM g.
//  Overflow: E >= 2**EXP_W-1 after rounding. Sets of=1, nx=1.
//    Result is inf for RNE/RMM, for RUP when positive, for RDN when negative.
//    Otherwise the result is the max finite {s,1..10,1..1}.
//  Underflow: E <= 0 after rounding. Result is signed zero with uf=1, nx=1. No subnormal output.
//  Reset mid-operation: all in-flight ops are discarded and out_valid drops asynchronously.
// CONFIGURATION
//  FP_MUL_STICKY_EN defined:
//    sticky |= flags on every output handshake (out_valid&out_ready).
//    sticky_clr=1 clears it; clear wins over a same-cycle update.
//    An op transferred in the clear cycle is not accumulated.
//  Undefined: sticky is tied to 0, sticky_clr is ignored and no accumulation logic is built.
// STRUCTURE
//  fp_mul_pkg: rmode_e enum, fp_class_e {ZERO,NORM,INF,QNAN,SNAN}, fp_flags_t struct {nv,of,uf,nx},
//    RM_* constants, canonical-NaN and max-finite helper functions parametrised on EXP_W/FRC_W.
//  Sub-module fp_mul_round (combinational S3 logic): normalise, round, overflow/underflow, pack.
//    The top keeps the pipeline registers and the handshake.
// TESTING (binary32 defaults)
//  T1 3.0*3.0: 0x40400000 x 0x40400000, RTZ -> 0x41100000, flags 0, out_valid exactly 3 cycles after accept.
//  T2 FTZ: 0x20000000 x 0x1F800000, RTZ -> 0x00000000, uf=1, nx=1. Subnormal 0x00400000 x 0x3F800000 -> 0x00000000, flags 0.
//  T3 specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, nv=1. 0x7F800001 x 0x3F800000 -> 0x7FC00000, nv=1.
//     0xFF800000 x 0x40000000 -> 0xFF800000, flags 0.
//  T4 overflow: 0x7F7FFFFF x 0x40000000: RNE -> 0x7F800000 {of,nx}; RTZ -> 0x7F7FFFFF; RDN with X negated -> 0xFF800000.
//  T5 back-pressure: issue 6 ops back-to-back with out_ready=0.
//     Required: in_ready=0 after 3 are accepted. Release -> 6 results in order, no loss, no duplicates, fp_z stable while stalled.
//  T6 reset mid-stream with 2 ops in flight -> out_valid=0 immediately, nothing emitted after release.
//     With FP_MUL_STICKY_EN: T4 then T3 -> sticky=4'b1101; sticky_clr -> 0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types, rounding-mode codes and format helpers for fp_mul_pipe
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  // Helpers return 64-bit images; callers size-cast to their own format width.
  function automatic logic [63:0] canon_nan(int ew, int fw);
    logic [63:0] v;
    v = ((64'd1 << ew) - 64'd1) << fw;
    v = v | (64'd1 << (fw - 1));
    return v;
  endfunction

  function automatic logic [63:0] max_finite(logic s, int ew, int fw);
    logic [63:0] v;
    v = (64'(s) << (ew + fw)) | (((64'd1 << ew) - 64'd2) << fw) | ((64'd1 << fw) - 64'd1);
    return v;
  endfunction

  function automatic fp_class_e classify(logic exp_zero, logic exp_ones, logic frac_zero,
                                         logic frac_msb);
    if (exp_zero) return ZERO;
    if (!exp_ones) return NORM;
    if (frac_zero) return INF;
    return frac_msb ? QNAN : SNAN;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational normalise, round, overflow/underflow and pack stage
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp_sum,
  input  logic [2*FRC_W+1:0]       prod,
  input  logic [2:0]               rm,
  output logic [EXP_W+FRC_W:0]     z,
  output fp_flags_t                flags
);

  localparam int PW = 2 * (FRC_W + 1);
  localparam logic signed [EXP_W+1:0] E_OVF = (EXP_W+2)'(2**EXP_W - 1);
  localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);

  logic                    norm_n, g, r, s, inc, carry, to_inf, ovf, unf;
  logic [PW-1:0]           sh;
  logic [FRC_W:0]          mant;
  logic [FRC_W+1:0]        sum;
  logic [FRC_W-1:0]        frac;
  logic signed [EXP_W+1:0] e_fin;

  always_comb begin
    norm_n = prod[PW-1];
    sh     = norm_n ? prod : (prod << 1);
    mant   = sh[PW-1 -: FRC_W+1];
    g      = sh[FRC_W];
    r      = sh[FRC_W-1];
    s      = |sh[FRC_W-2:0];

    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = !sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (r | s | mant[0]);
    endcase

    sum   = {1'b0, mant} + {{(FRC_W+1){1'b0}}, inc};
    carry = sum[FRC_W+1];
    frac  = carry ? sum[FRC_W:1] : sum[FRC_W-1:0];
    e_fin = exp_sum + $signed({{(EXP_W+1){1'b0}}, norm_n}) + $signed({{(EXP_W+1){1'b0}}, carry});
    ovf   = e_fin >= E_OVF;
    unf   = e_fin < E_ONE;

    // Directed modes that round away from the overflow sign saturate to max finite.
    case (rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign;
      RM_RUP:  to_inf = !sign;
      default: to_inf = 1'b1;
    endcase

    flags    = '0;
    flags.nx = g | r | s;
    z        = {sign, e_fin[EXP_W-1:0], frac};
    if (ovf) begin
      flags.of = 1'b1;
      flags.nx = 1'b1;
      z = to_inf ? {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                 : (EXP_W+FRC_W+1)'(max_finite(sign, EXP_W, FRC_W));
    end else if (unf) begin
      flags.uf = 1'b1;
      flags.nx = 1'b1;
      z = {sign, {(EXP_W+FRC_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage FTZ/DAZ IEEE-754 multiplier with valid/ready; FP_MUL_STICKY_EN enables sticky flags
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+FRC_W:0] fp_x,
  input  logic [EXP_W+FRC_W:0] fp_y,
  input  logic [2:0]           r_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+FRC_W:0] fp_z,
  output logic [3:0]           flags,
  output logic [3:0]           sticky,
  input  logic                 sticky_clr
);

  localparam int W  = EXP_W + FRC_W + 1;
  localparam int SW = FRC_W + 1;
  localparam int PW = 2 * SW;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(2**(EXP_W-1) - 1);

  logic adv1, adv2, adv3, v1, v2, v3;

  assign adv3      = !v3 | out_ready;
  assign adv2      = !v2 | adv3;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  logic [EXP_W-1:0]        ex, ey;
  logic [FRC_W-1:0]        fx, fy;
  fp_class_e               cx, cy;
  logic                    sign_c, spec_c, inf_zero;
  logic [W-1:0]            spec_z_c;
  fp_flags_t               spec_f_c;
  logic signed [EXP_W+1:0] esum_c;

  always_comb begin
    ex       = fp_x[W-2:FRC_W];
    ey       = fp_y[W-2:FRC_W];
    fx       = fp_x[FRC_W-1:0];
    fy       = fp_y[FRC_W-1:0];
    cx       = classify(ex == '0, &ex, fx == '0, fx[FRC_W-1]);
    cy       = classify(ey == '0, &ey, fy == '0, fy[FRC_W-1]);
    sign_c   = fp_x[W-1] ^ fp_y[W-1];
    esum_c   = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;
    inf_zero = (cx == INF && cy == ZERO) || (cx == ZERO && cy == INF);
    spec_c   = 1'b1;
    spec_f_c = '0;
    spec_z_c = '0;
    // Special operands resolve entirely here and bypass the arithmetic path.
    if (cx == QNAN || cx == SNAN || cy == QNAN || cy == SNAN || inf_zero) begin
      spec_z_c    = W'(canon_nan(EXP_W, FRC_W));
      spec_f_c.nv = inf_zero || cx == SNAN || cy == SNAN;
    end else if (cx == INF || cy == INF) begin
      spec_z_c = {sign_c, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    end else if (cx == ZERO || cy == ZERO) begin
      spec_z_c = {sign_c, {(W-1){1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  logic                    s1_sign, s1_spec, s2_sign, s2_spec;
  logic signed [EXP_W+1:0] s1_esum, s2_esum;
  logic [SW-1:0]           s1_mx, s1_my;
  logic [PW-1:0]           s2_prod;
  logic [2:0]              s1_rm, s2_rm;
  logic [W-1:0]            s1_spec_z, s2_spec_z, rnd_z;
  fp_flags_t               s1_spec_f, s2_spec_f, rnd_f, flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      fp_z    <= '0;
      flags_q <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        fp_z    <= s2_spec ? s2_spec_z : rnd_z;
        flags_q <= s2_spec ? s2_spec_f : rnd_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sign   <= sign_c;
      s1_esum   <= esum_c;
      s1_mx     <= {1'b1, fx};
      s1_my     <= {1'b1, fy};
      s1_rm     <= r_mode;
      s1_spec   <= spec_c;
      s1_spec_z <= spec_z_c;
      s1_spec_f <= spec_f_c;
    end
    if (adv2 && v1) begin
      s2_sign   <= s1_sign;
      s2_esum   <= s1_esum;
      s2_prod   <= PW'(s1_mx) * PW'(s1_my);
      s2_rm     <= s1_rm;
      s2_spec   <= s1_spec;
      s2_spec_z <= s1_spec_z;
      s2_spec_f <= s1_spec_f;
    end
  end

  fp_mul_round #(.EXP_W(EXP_W), .FRC_W(FRC_W)) u_round (
    .sign    (s2_sign),
    .exp_sum (s2_esum),
    .prod    (s2_prod),
    .rm      (s2_rm),
    .z       (rnd_z),
    .flags   (rnd_f)
  );

  assign flags = flags_q;

`ifdef FP_MUL_STICKY_EN
  // Clear has priority, so a result delivered in the clear cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky <= '0;
    else if (sticky_clr) sticky <= '0;
    else if (v3 && out_ready) sticky <= sticky | flags_q;
  end
`else
  assign sticky = {4{1'b0 & sticky_clr}};
`endif

endmodule
